// File: rtl/win_2048_pic_fetch.sv
// Pixel-fetch stage for the 2048 win picture: maps screen coordinates onto a scaled
// image window, addresses the picture ROM and emits a 2-clock-latency palette index.
module win_2048_pic_fetch #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 1,
    parameter int ORIGIN_X    = 160,
    parameter int ORIGIN_Y    = 120,
    parameter int ADDR_W      = 15
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              show,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              de,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [4:0]        pix_index,
    output logic              pix_valid,
    output logic              active,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHOW  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + (IMG_W << SCALE_SHIFT));
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (IMG_H << SCALE_SHIFT));

    state_t            state;
    state_t            state_nxt;
    logic              fs;
    logic              drawing;
    logic              hit;
    logic              hit_d1;
    logic [10:0]       x11;
    logic [10:0]       y11;
    logic [10:0]       u;
    logic [10:0]       v;
    logic [ADDR_W-1:0] addr;

    assign fs = (DrawX == 10'd0) && (DrawY == 10'd0);

    // Show/hide only changes at frame start; DRAIN finishes the frame already begun.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (show) state_nxt = ARM;
            ARM:     if (!show) state_nxt = IDLE;
                     else if (fs) state_nxt = SHOW;
            SHOW:    if (!show) state_nxt = DRAIN;
            DRAIN:   if (fs) state_nxt = show ? SHOW : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The frame-start pixel is judged with the state it transitions into.
    assign drawing = (state_nxt == SHOW) || (state_nxt == DRAIN);

    // 11-bit compare keeps windows that extend past 1023 from wrapping.
    assign x11 = {1'b0, DrawX};
    assign y11 = {1'b0, DrawY};
    assign hit = de && drawing &&
                 (x11 >= X_LO) && (x11 < X_HI) &&
                 (y11 >= Y_LO) && (y11 < Y_HI);

    assign u    = (x11 - X_LO) >> SCALE_SHIFT;
    assign v    = (y11 - Y_LO) >> SCALE_SHIFT;
    assign addr = ADDR_W'(v) * ADDR_W'(IMG_W) + ADDR_W'(u);

    // pix_valid qualifies pix_index in the same cycle; there is no backpressure.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            active    <= 1'b0;
            hit_d1    <= 1'b0;
            rom_addr  <= '0;
            pix_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            state     <= state_nxt;
            active    <= drawing;
            hit_d1    <= hit;
            if (hit) rom_addr <= addr;
            pix_valid <= hit_d1;
            pix_index <= hit_d1 ? rom_data : 5'd0;
        end
    end

    assign dbg_state = state;

endmodule
